uart_rx_parity: RTL and testbench
=================================

Name: uart_rx_parity

Overview:
UART receiver with parity check. Sits directly upstream of the 4-digit hex display and produces its 16-bit data word. Deserialises 8-bit frames with one parity bit from the rx pin and checks parity. The high display byte shows the last good byte; the low display byte shows a saturating parity-error count.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected
(derived, local) CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, must be >= 4

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idles high
data  output  16  display word {last_good_byte[7:0], err_count[7:0]}; connects to the hex display data input
byte_valid  output  1  one-cycle pulse per completed frame that has a valid stop bit
byte_data  output  8  received byte; valid while byte_valid=1 and held afterwards
parity_err  output  1  one-cycle pulse, coincident with byte_valid, when the parity bit mismatches
frame_err  output  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset (sampled on posedge clk while rst=1):
  - state=IDLE; synchroniser flops=1; bit counter and baud counter=0.
  - data=16'h0000; byte_data=8'h00.
  - byte_valid, parity_err, frame_err=0.
- rx passes through a 2-flop synchroniser before any use. All sampling uses the synchronised signal rx_s.
- Baud counter counts 0..CLKS_PER_BIT-1 and is cleared on every state entry. A bit is sampled when the counter reaches its terminal value. START uses a half-bit terminal, CLKS_PER_BIT/2-1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s=0, go to START.
  - START: at the half-bit point, if rx_s=0 go to DATA; if rx_s=1 treat it as a glitch and return to IDLE with no outputs.
  - DATA: after each full bit time, sample rx_s into the shift register, LSB first. After 8 samples, go to PARITY.
  - PARITY: after one bit time, sample the parity bit p. Mismatch when (^shift) ^ p ^ PARITY_ODD = 1. Go to STOP.
  - STOP: after one bit time, sample rx_s.
    - rx_s=1: pulse byte_valid, load byte_data=shift, and pulse parity_err on a mismatch.
    - rx_s=0: pulse frame_err only. byte_valid, byte_data and data are unchanged.
    - Either way, go to IDLE.
- data update, same clock edge as byte_valid:
  - Parity good: data[15:8] <= byte.
  - Parity bad: data[15:8] unchanged; data[7:0] <= data[7:0]+1, saturating at 8'hFF (no wrap).
- Pulses are registered, exactly 1 cycle wide, and never assert outside STOP completion.
- Latency: byte_valid rises 2 + CLKS_PER_BIT/2 + 10*CLKS_PER_BIT cycles (+/-1) after the rx falling edge at the pin.
- Back-to-back frames: IDLE detects a new start bit on the cycle after the STOP sample. A frame whose start bit begins immediately at the stop-bit end must be received correctly.
- rx held low continuously: produces a frame with byte 0x00, then frame_err; the FSM then re-enters START repeatedly. No lockup.
- rst asserted mid-frame: abort immediately to the reset values. A partial frame produces no pulses and does not modify data.
- rx is ignored while rst=1.

Test Plan:
- CLK_FREQ=1000000, BAUD=100000 (CLKS_PER_BIT=10), even parity; after reset send 0x55 with p=0 -> one byte_valid, byte_data=0x55, parity_err=0, data=16'h5500.
- Then send 0xA7 with p=1 (five ones) -> byte_valid, data=16'hA700. Then send 0xA7 with p=0 -> byte_valid plus parity_err, data=16'hA701.
- Stop bit forced low on 0x3C -> frame_err pulse only, no byte_valid, data unchanged. Next good frame 0x12 is received correctly -> data[15:8]=0x12.
- 3-cycle low glitch on rx while IDLE -> no pulses; FSM back in IDLE; a following valid frame is received.
- 260 consecutive bad-parity frames -> err_count saturates at 8'hFF, does not wrap. Back-to-back frames with zero idle gap are all counted.
- Assert rst for 1 cycle in the middle of DATA bits -> all outputs return to their reset values, no pulses. The next full frame 0xF0 with p=0 -> data=16'hF000.
- PARITY_ODD=1: 0x55 with p=1 -> good; with p=0 -> parity_err.

Source files
------------

// File: rtl/uart_rx_parity_if.sv
// Bundle between the UART receiver and its consumers: serial line in, display word and frame status out.
// The receiver uses the master modport; the display side and the bench use the slave modport.
interface uart_rx_parity_if;
    logic        rx;
    logic [15:0] data;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        parity_err;
    logic        frame_err;

    modport master (
        input  rx,
        output data,
        output byte_valid,
        output byte_data,
        output parity_err,
        output frame_err
    );

    modport slave (
        output rx,
        input  data,
        input  byte_valid,
        input  byte_data,
        input  parity_err,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx_parity.sv
// 8-bit UART receiver with one parity bit. It drives a 16-bit display word:
// {last good byte, saturating parity-error count}.
module uart_rx_parity #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    uart_rx_parity_if.master  uart
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_TERM = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TERM = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity_mismatch(input logic [7:0] b, input logic p, input logic odd);
        return (^b) ^ p ^ odd;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t         state_q;
    logic           sync1_q, sync2_q;
    logic [CW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           par_bad_q;
    logic [7:0]     last_good_q;
    logic [7:0]     err_cnt_q;
    logic [7:0]     byte_data_q;
    logic           byte_valid_q, parity_err_q, frame_err_q;

    logic           rx_s;
    logic [CW-1:0]  baud_term_s;
    logic           baud_done_s;
    logic [CW-1:0]  baud_d;
    logic [7:0]     err_cnt_d;
    logic           par_bad_d;

    assign rx_s = sync2_q;

    // Baud timing (half bit in START to land mid-bit), saturating count and parity evaluation.
    always_comb begin
        baud_term_s = (state_q == ST_START) ? HALF_TERM : FULL_TERM;
        baud_done_s = (baud_q == baud_term_s);
        baud_d      = baud_done_s ? {CW{1'b0}} : baud_q + CW'(1);
        err_cnt_d   = sat_inc(err_cnt_q);
        par_bad_d   = parity_mismatch(shift_q, rx_s, PARITY_ODD);
    end

    // Synchroniser, receive FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            baud_q       <= {CW{1'b0}};
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            par_bad_q    <= 1'b0;
            last_good_q  <= 8'h00;
            err_cnt_q    <= 8'h00;
            byte_data_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= uart.rx;
            sync2_q      <= sync1_q;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    baud_q <= {CW{1'b0}};
                    bit_q  <= 3'd0;
                    if (!rx_s) state_q <= ST_START;
                end
                ST_START: begin
                    baud_q <= baud_d;
                    if (baud_done_s) state_q <= rx_s ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    baud_q <= baud_d;
                    if (baud_done_s) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    baud_q <= baud_d;
                    if (baud_done_s) begin
                        par_bad_q <= par_bad_d;
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    baud_q <= baud_d;
                    if (baud_done_s) begin
                        state_q <= ST_IDLE;
                        if (rx_s) begin
                            byte_valid_q <= 1'b1;
                            byte_data_q  <= shift_q;
                            parity_err_q <= par_bad_q;
                            if (par_bad_q) err_cnt_q   <= err_cnt_d;
                            else           last_good_q <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    baud_q  <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign uart.data       = {last_good_q, err_cnt_q};
    assign uart.byte_valid = byte_valid_q;
    assign uart.byte_data  = byte_data_q;
    assign uart.parity_err = parity_err_q;
    assign uart.frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_rx_parity.sv
// Directed bench for uart_rx_parity at 10 clocks per bit: an even-parity instance and an odd-parity instance.
module tb_uart_rx_parity;
    localparam int CPB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_parity_if if_e ();
    uart_rx_parity_if if_o ();

    uart_rx_parity #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY_ODD(1'b0))
        dut_e (.clk(clk), .rst(rst), .uart(if_e));
    uart_rx_parity #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY_ODD(1'b1))
        dut_o (.clk(clk), .rst(rst), .uart(if_o));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int bv_e = 0, pe_e = 0, fe_e = 0, bv_cyc_e = 0;
    int bv_o = 0, pe_o = 0, fe_o = 0;
    int orphan = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (if_e.byte_valid === 1'b1) begin bv_e = bv_e + 1; bv_cyc_e = cyc; end
        if (if_e.parity_err === 1'b1) begin
            pe_e = pe_e + 1;
            if (if_e.byte_valid !== 1'b1) orphan = orphan + 1;
        end
        if (if_e.frame_err === 1'b1) begin
            fe_e = fe_e + 1;
            if (if_e.byte_valid !== 1'b0) orphan = orphan + 1;
        end
        if (if_o.byte_valid === 1'b1) bv_o = bv_o + 1;
        if (if_o.parity_err === 1'b1) begin
            pe_o = pe_o + 1;
            if (if_o.byte_valid !== 1'b1) orphan = orphan + 1;
        end
        if (if_o.frame_err === 1'b1) fe_o = fe_o + 1;
    end

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) if_o.rx = v;
        else     if_e.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic stop,
                              input bit sel, input int gap);
        start_cyc = cyc;
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, b[i]);
        drive_bit(sel, p);
        drive_bit(sel, stop);
        if (sel) if_o.rx = 1'b1;
        else     if_e.rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        if_e.rx = 1'b1;
        if_o.rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        if_e.rx = 1'b0;
        repeat (2) @(negedge clk);
        if_e.rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if_e.data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", if_e.data); end
        checks++;
        if (if_e.byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h expected 00", if_e.byte_data); end
        checks++;
        if ({if_e.byte_valid, if_e.parity_err, if_e.frame_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 000", {if_e.byte_valid, if_e.parity_err, if_e.frame_err});
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bv_e + pe_e + fe_e !== 0) begin errors++; $display("FAIL reset_no_pulses: got %0d expected 0", bv_e + pe_e + fe_e); end
    endtask

    task automatic test_basic();
        int b0, p0, lat;
        b0 = bv_e; p0 = pe_e;
        send_frame(8'h55, 1'b0, 1'b1, 1'b0, 10);
        lat = bv_cyc_e - start_cyc;
        checks++;
        if (bv_e - b0 !== 1) begin errors++; $display("FAIL basic_valid_count: got %0d expected 1", bv_e - b0); end
        checks++;
        if (if_e.byte_data !== 8'h55) begin errors++; $display("FAIL basic_byte: got %h expected 55", if_e.byte_data); end
        checks++;
        if (pe_e - p0 !== 0) begin errors++; $display("FAIL basic_parity: got %0d expected 0", pe_e - p0); end
        checks++;
        if (if_e.data !== 16'h5500) begin errors++; $display("FAIL basic_data: got %h expected 5500", if_e.data); end
        checks++;
        if (lat < 106 || lat > 108) begin errors++; $display("FAIL basic_latency: got %0d expected 106..108", lat); end
    endtask

    task automatic test_parity();
        int b0, p0;
        b0 = bv_e; p0 = pe_e;
        send_frame(8'hA7, 1'b1, 1'b1, 1'b0, 10);
        checks++;
        if (if_e.data !== 16'hA700) begin errors++; $display("FAIL parity_good_data: got %h expected A700", if_e.data); end
        checks++;
        if (pe_e - p0 !== 0) begin errors++; $display("FAIL parity_good_err: got %0d expected 0", pe_e - p0); end
        send_frame(8'hA7, 1'b0, 1'b1, 1'b0, 10);
        checks++;
        if (pe_e - p0 !== 1) begin errors++; $display("FAIL parity_bad_err: got %0d expected 1", pe_e - p0); end
        checks++;
        if (bv_e - b0 !== 2) begin errors++; $display("FAIL parity_valid_count: got %0d expected 2", bv_e - b0); end
        checks++;
        if (if_e.data !== 16'hA701) begin errors++; $display("FAIL parity_bad_data: got %h expected A701", if_e.data); end
    endtask

    task automatic test_frame_err();
        int b0, f0;
        b0 = bv_e; f0 = fe_e;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 20);
        checks++;
        if (fe_e - f0 !== 1) begin errors++; $display("FAIL frame_err_count: got %0d expected 1", fe_e - f0); end
        checks++;
        if (bv_e - b0 !== 0) begin errors++; $display("FAIL frame_err_valid: got %0d expected 0", bv_e - b0); end
        checks++;
        if (if_e.data !== 16'hA701 || if_e.byte_data !== 8'hA7) begin
            errors++; $display("FAIL frame_err_hold: got %h/%h expected A701/A7", if_e.data, if_e.byte_data);
        end
        send_frame(8'h12, 1'b0, 1'b1, 1'b0, 10);
        checks++;
        if (if_e.data !== 16'h1201) begin errors++; $display("FAIL frame_err_recover: got %h expected 1201", if_e.data); end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = bv_e + pe_e + fe_e;
        if_e.rx = 1'b0;
        repeat (3) @(negedge clk);
        if_e.rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (bv_e + pe_e + fe_e - s0 !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", bv_e + pe_e + fe_e - s0); end
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 10);
        checks++;
        if (if_e.data !== 16'h8101) begin errors++; $display("FAIL glitch_next_frame: got %h expected 8101", if_e.data); end
    endtask

    task automatic test_held_low();
        int b0, f0;
        b0 = bv_e; f0 = fe_e;
        if_e.rx = 1'b0;
        repeat (215) @(negedge clk);
        if_e.rx = 1'b1;
        repeat (30) @(negedge clk);
        checks++;
        if (fe_e - f0 !== 2) begin errors++; $display("FAIL held_low_frame_errs: got %0d expected 2", fe_e - f0); end
        checks++;
        if (bv_e - b0 !== 0) begin errors++; $display("FAIL held_low_valid: got %0d expected 0", bv_e - b0); end
        send_frame(8'h66, 1'b0, 1'b1, 1'b0, 10);
        checks++;
        if (if_e.data !== 16'h6601) begin errors++; $display("FAIL held_low_recover: got %h expected 6601", if_e.data); end
    endtask

    task automatic test_back_to_back();
        int b0;
        b0 = bv_e;
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h7F, 1'b1, 1'b1, 1'b0, 10);
        checks++;
        if (bv_e - b0 !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bv_e - b0); end
        checks++;
        if (if_e.data !== 16'h7F01) begin errors++; $display("FAIL b2b_data: got %h expected 7F01", if_e.data); end
    endtask

    task automatic test_saturation();
        int b0, p0;
        b0 = bv_e; p0 = pe_e;
        for (int i = 0; i < 253; i++) send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (if_e.data !== 16'h7FFE) begin errors++; $display("FAIL sat_before: got %h expected 7FFE", if_e.data); end
        for (int i = 0; i < 7; i++) send_frame(8'h01, 1'b0, 1'b1, 1'b0, 0);
        checks++;
        if (if_e.data !== 16'h7FFF) begin errors++; $display("FAIL sat_hold: got %h expected 7FFF", if_e.data); end
        checks++;
        if (bv_e - b0 !== 260 || pe_e - p0 !== 260) begin
            errors++; $display("FAIL sat_counts: got %0d/%0d expected 260/260", bv_e - b0, pe_e - p0);
        end
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 10);
        checks++;
        if (if_e.data !== 16'hC3FF) begin errors++; $display("FAIL sat_good_after: got %h expected C3FF", if_e.data); end
    endtask

    task automatic test_mid_reset();
        int s0;
        s0 = bv_e + pe_e + fe_e;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b0);
        rst = 1'b1;
        if_e.rx = 1'b1;
        @(negedge clk);
        checks++;
        if (if_e.data !== 16'h0000 || if_e.byte_data !== 8'h00) begin
            errors++; $display("FAIL midrst_values: got %h/%h expected 0000/00", if_e.data, if_e.byte_data);
        end
        rst = 1'b0;
        repeat (150) @(negedge clk);
        checks++;
        if (bv_e + pe_e + fe_e - s0 !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d expected 0", bv_e + pe_e + fe_e - s0); end
        checks++;
        if (if_e.data !== 16'h0000) begin errors++; $display("FAIL midrst_data_kept: got %h expected 0000", if_e.data); end
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 10);
        checks++;
        if (if_e.data !== 16'hF000) begin errors++; $display("FAIL midrst_next_frame: got %h expected F000", if_e.data); end
    endtask

    task automatic test_odd_parity();
        int b0, p0;
        b0 = bv_o; p0 = pe_o;
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 10);
        checks++;
        if (if_o.data !== 16'h5500 || pe_o - p0 !== 0) begin
            errors++; $display("FAIL odd_good: got %h/%0d expected 5500/0", if_o.data, pe_o - p0);
        end
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, 10);
        checks++;
        if (pe_o - p0 !== 1 || bv_o - b0 !== 2) begin
            errors++; $display("FAIL odd_bad_pulses: got pe %0d bv %0d expected 1 2", pe_o - p0, bv_o - b0);
        end
        checks++;
        if (if_o.data !== 16'h5501) begin errors++; $display("FAIL odd_bad_data: got %h expected 5501", if_o.data); end
        checks++;
        if (if_e.data !== 16'hF000) begin errors++; $display("FAIL odd_isolation: got %h expected F000", if_e.data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_held_low();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_odd_parity();
        checks++;
        if (orphan !== 0) begin errors++; $display("FAIL pulse_coincidence: got %0d expected 0", orphan); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
